// File: rtl/pacman_life_ctrl.sv
// rtl/pacman_life_ctrl.sv - pacman/ghost collision detection and life/respawn/game-over sequencing
// Optional build macro: PACMAN_EXTRA_LIFE_EN adds the extra_life pulse input.
// Overlap is judged per ghost on |dx| and |dy| against HIT_RADIUS. The FSM walks
// PLAY -> DYING -> RESPAWN -> PLAY, or DYING -> OVER once the last life is gone.
// Every output is registered, so a response appears one frame after its cause.
module pacman_life_ctrl #(
  parameter int NUM_GHOSTS   = 4,
  parameter int START_LIVES  = 3,
  parameter int HIT_RADIUS   = 6,
  parameter int DEATH_FRAMES = 60
) (
  input  logic                      Reset,
  input  logic                      frame_clk,
  input  logic [9:0]                pac_x,
  input  logic [9:0]                pac_y,
  input  logic                      has_moved,
  input  logic [10*NUM_GHOSTS-1:0]  ghost_x,
  input  logic [10*NUM_GHOSTS-1:0]  ghost_y,
  input  logic [NUM_GHOSTS-1:0]     ghost_frightened,
`ifdef PACMAN_EXTRA_LIFE_EN
  input  logic                      extra_life,
`endif
  output logic                      isDefeated,
  output logic                      death,
  output logic [2:0]                lives,
  output logic [NUM_GHOSTS-1:0]     ghost_eaten,
  output logic                      game_over
);

  // Frame counter only has to reach DEATH_FRAMES-1.
  localparam int CW = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;
  localparam logic [CW-1:0] LAST_FRAME = CW'(DEATH_FRAMES - 1);
  localparam logic [10:0]   RADIUS     = 11'(HIT_RADIUS);
  localparam logic [2:0]    LIVES_INIT = 3'(START_LIVES);
  localparam logic [2:0]    LIVES_MAX  = 3'd7;

  typedef enum logic [1:0] {
    S_PLAY    = 2'd0,
    S_DYING   = 2'd1,
    S_RESPAWN = 2'd2,
    S_OVER    = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [2:0]            r_lives;
  logic [2:0]            w_lives_nxt;
  logic                  r_death;
  logic                  w_death_nxt;
  logic                  r_defeat;
  logic                  w_defeat_nxt;
  logic                  r_over;
  logic                  w_over_nxt;
  logic [NUM_GHOSTS-1:0] r_eaten;
  logic [NUM_GHOSTS-1:0] w_eaten_nxt;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [NUM_GHOSTS-1:0] r_hist;

  logic [NUM_GHOSTS-1:0] w_hit;
  logic                  w_lethal;
  logic [NUM_GHOSTS-1:0] w_fright_rise;
  logic                  w_extra;

  // Absolute difference of two 10-bit coordinates; bit 10 of the 11-bit
  // difference is the sign because the operands are zero-extended.
  function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    logic [10:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[10] ? (11'd0 - d) : d;
  endfunction

`ifdef PACMAN_EXTRA_LIFE_EN
  assign w_extra = extra_life;
`else
  assign w_extra = 1'b0;
`endif

  // Per-ghost overlap test on the current inputs.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_GHOSTS; i++) begin
      w_hit[i] = (abs_diff(pac_x, ghost_x[10*i +: 10]) < RADIUS) &&
                 (abs_diff(pac_y, ghost_y[10*i +: 10]) < RADIUS);
    end
  end

  // A lethal hit is level-based; eating needs a fresh overlap edge.
  assign w_lethal      = |(w_hit & ~ghost_frightened);
  assign w_fright_rise = w_hit & ~r_hist & ghost_frightened;

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_lives_nxt  = r_lives;
    w_death_nxt  = r_death;
    w_defeat_nxt = 1'b0;
    w_over_nxt   = r_over;
    w_eaten_nxt  = '0;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      S_PLAY: begin
        if (has_moved && w_lethal) begin
          // Extra life and a lethal hit in the same frame cancel out.
          if (!w_extra && r_lives != 3'd0) begin
            w_lives_nxt = r_lives - 3'd1;
          end
          w_death_nxt = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_DYING;
        end else begin
          if (has_moved) begin
            w_eaten_nxt = w_fright_rise;
          end
          if (w_extra && r_lives != LIVES_MAX) begin
            w_lives_nxt = r_lives + 3'd1;
          end
        end
      end
      S_DYING: begin
        w_death_nxt = 1'b1;
        w_cnt_nxt   = r_cnt + CW'(1);
        if (r_cnt == LAST_FRAME) begin
          if (r_lives == 3'd0) begin
            w_over_nxt  = 1'b1;
            w_state_nxt = S_OVER;
          end else begin
            w_death_nxt  = 1'b0;
            w_defeat_nxt = 1'b1;
            w_state_nxt  = S_RESPAWN;
          end
        end
      end
      S_RESPAWN: begin
        // Pacman is back at the centre once the movement block drops hasMoved.
        if (!has_moved) begin
          w_state_nxt = S_PLAY;
        end
      end
      S_OVER: begin
        w_death_nxt = 1'b1;
        w_over_nxt  = 1'b1;
        w_lives_nxt = 3'd0;
      end
      default: begin
        w_state_nxt = S_PLAY;
      end
    endcase
  end

  // State and registered outputs; overlap history follows hits in every state.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= S_PLAY;
      r_lives  <= LIVES_INIT;
      r_death  <= 1'b0;
      r_defeat <= 1'b0;
      r_over   <= 1'b0;
      r_eaten  <= '0;
      r_cnt    <= '0;
      r_hist   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_lives  <= w_lives_nxt;
      r_death  <= w_death_nxt;
      r_defeat <= w_defeat_nxt;
      r_over   <= w_over_nxt;
      r_eaten  <= w_eaten_nxt;
      r_cnt    <= w_cnt_nxt;
      r_hist   <= w_hit;
    end
  end

  assign isDefeated  = r_defeat;
  assign death       = r_death;
  assign lives       = r_lives;
  assign ghost_eaten = r_eaten;
  assign game_over   = r_over;

endmodule

// File: tb/tb_pacman_life_ctrl.sv
// tb/tb_pacman_life_ctrl.sv - directed and random bench for pacman_life_ctrl against a frame-level model
module tb_pacman_life_ctrl;

  localparam int NG = 4;
  localparam int SL = 3;
  localparam int HR = 6;
  localparam int DF = 60;

  logic               Reset;
  logic               frame_clk;
  logic [9:0]         pac_x;
  logic [9:0]         pac_y;
  logic               has_moved;
  logic [10*NG-1:0]   ghost_x;
  logic [10*NG-1:0]   ghost_y;
  logic [NG-1:0]      ghost_frightened;
  logic               isDefeated;
  logic               death;
  logic [2:0]         lives;
  logic [NG-1:0]      ghost_eaten;
  logic               game_over;
`ifdef PACMAN_EXTRA_LIFE_EN
  logic               extra_life;
`endif

  pacman_life_ctrl #(
    .NUM_GHOSTS(NG), .START_LIVES(SL), .HIT_RADIUS(HR), .DEATH_FRAMES(DF)
  ) dut (
    .Reset(Reset),
    .frame_clk(frame_clk),
    .pac_x(pac_x),
    .pac_y(pac_y),
    .has_moved(has_moved),
    .ghost_x(ghost_x),
    .ghost_y(ghost_y),
    .ghost_frightened(ghost_frightened),
`ifdef PACMAN_EXTRA_LIFE_EN
    .extra_life(extra_life),
`endif
    .isDefeated(isDefeated),
    .death(death),
    .lives(lives),
    .ghost_eaten(ghost_eaten),
    .game_over(game_over)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  int total = 0;
  int bad   = 0;

  // Stimulus in plain integers.
  int px, py;
  int gx[NG];
  int gy[NG];
  logic [NG-1:0] fr;
  logic          mv;
  logic          xl;

  // Frame-level model: lives, a count of frozen frames still to go,
  // whether we are waiting for pacman to be recentred, and game over.
  int            m_lives;
  int            m_freeze;
  bit            m_wait_centre;
  bit            m_over;
  bit            m_death;
  bit            m_defeat;
  logic [NG-1:0] m_eaten;
  bit            m_prev_hit[NG];

  task automatic model_reset();
    m_lives       = SL;
    m_freeze      = 0;
    m_wait_centre = 0;
    m_over        = 0;
    m_death       = 0;
    m_defeat      = 0;
    m_eaten       = '0;
    for (int i = 0; i < NG; i++) m_prev_hit[i] = 0;
  endtask

  task automatic model_frame();
    bit hit[NG];
    bit lethal;
    int dx, dy, delta;
    lethal = 0;
    for (int i = 0; i < NG; i++) begin
      dx = px - gx[i]; if (dx < 0) dx = -dx;
      dy = py - gy[i]; if (dy < 0) dy = -dy;
      hit[i] = (dx < HR) && (dy < HR);
      if (hit[i] && !fr[i]) lethal = 1;
    end
    m_defeat = 0;
    m_eaten  = '0;
    if (m_over) begin
      // frozen forever
    end else if (m_freeze > 0) begin
      m_freeze--;
      if (m_freeze == 0) begin
        if (m_lives == 0) m_over = 1;
        else begin
          m_death       = 0;
          m_defeat      = 1;
          m_wait_centre = 1;
        end
      end
    end else if (m_wait_centre) begin
      if (!mv) m_wait_centre = 0;
    end else begin
      delta = 0;
`ifdef PACMAN_EXTRA_LIFE_EN
      if (xl) delta = 1;
`endif
      if (mv && lethal) begin
        delta   -= 1;
        m_death  = 1;
        m_freeze = DF;
      end else if (mv) begin
        for (int i = 0; i < NG; i++)
          if (hit[i] && !m_prev_hit[i] && fr[i]) m_eaten[i] = 1'b1;
      end
      m_lives += delta;
      if (m_lives < 0) m_lives = 0;
      if (m_lives > 7) m_lives = 7;
    end
    for (int i = 0; i < NG; i++) m_prev_hit[i] = hit[i];
  endtask

  task automatic chk(input string tag, input int got, input int want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".death"},      int'(death),       int'(m_death));
    chk({tag, ".isDefeated"}, int'(isDefeated),  int'(m_defeat));
    chk({tag, ".lives"},      int'(lives),       m_lives);
    chk({tag, ".ghost_eaten"},int'(ghost_eaten), int'(m_eaten));
    chk({tag, ".game_over"},  int'(game_over),   int'(m_over));
  endtask

  task automatic drive();
    pac_x = 10'(px);
    pac_y = 10'(py);
    has_moved = mv;
    ghost_frightened = fr;
    for (int i = 0; i < NG; i++) begin
      ghost_x[10*i +: 10] = 10'(gx[i]);
      ghost_y[10*i +: 10] = 10'(gy[i]);
    end
`ifdef PACMAN_EXTRA_LIFE_EN
    extra_life = xl;
`endif
  endtask

  task automatic tick(input string tag);
    drive();
    @(posedge frame_clk);
    model_frame();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    #2 Reset = 1'b1;
    model_reset();
    #1 check_all("reset");
    #1 Reset = 1'b0;
  endtask

  task automatic ghosts_away();
    for (int i = 0; i < NG; i++) begin
      gx[i] = 20 + 30 * i;
      gy[i] = 20;
    end
    fr = '0;
  endtask

  task automatic run_out_death(input string tag);
    for (int k = 0; k < DF; k++) tick(tag);
    mv = 1'b0; tick(tag);
    mv = 1'b1;
  endtask

  int n_defeat;

  initial begin
    Reset = 1'b1;
    px = 304; py = 248; mv = 1'b0; xl = 1'b0;
    ghosts_away();
    drive();
    model_reset();
    #1 check_all("reset0");
    @(negedge frame_clk);
    Reset = 1'b0;

    // Spawn grace
    gx[0] = 304; gy[0] = 248;
    for (int k = 0; k < 10; k++) tick("grace");
    chk("grace.lives", int'(lives), 3);
    chk("grace.death", int'(death), 0);

    // Lethal hit, full freeze, single isDefeated, recentre
    mv = 1'b1; gx[0] = 309;
    tick("lethal");
    chk("lethal.death", int'(death), 1);
    chk("lethal.lives", int'(lives), 2);
    for (int k = 0; k < DF - 1; k++) tick("freeze");
    chk("freeze.end_death", int'(death), 1);
    tick("release");
    chk("release.isDefeated", int'(isDefeated), 1);
    chk("release.death", int'(death), 0);
    tick("respawn_wait");
    chk("respawn.pulse_len", int'(isDefeated), 0);
    mv = 1'b0; tick("recentre");
    mv = 1'b1;

    // Radius boundary
    gx[0] = 310; gy[0] = 248; tick("edge_dx6");
    chk("edge_dx6.death", int'(death), 0);
    gx[0] = 298; gy[0] = 243; tick("edge_dxdy6");
    chk("edge_dxdy6.death", int'(death), 0);
    gx[0] = 299; gy[0] = 244; tick("edge_in");
    chk("edge_in.death", int'(death), 1);
    ghosts_away();
    run_out_death("edge_out");

    // Frightened eat, then eat masked by lethal
    do_reset();
    mv = 1'b1;
    gx[1] = 304; gy[1] = 248; fr[1] = 1'b1;
    tick("eat0");
    chk("eat0.ghost_eaten", int'(ghost_eaten), 2);
    for (int k = 0; k < 4; k++) tick("eat_hold");
    chk("eat_hold.ghost_eaten", int'(ghost_eaten), 0);
    chk("eat_hold.lives", int'(lives), 3);
    gx[2] = 302; gy[2] = 250;
    gx[3] = 306; gy[3] = 246; fr[3] = 1'b1;
    tick("eat_vs_lethal");
    chk("eat_vs_lethal.ghost_eaten", int'(ghost_eaten), 0);
    chk("eat_vs_lethal.death", int'(death), 1);
    ghosts_away();
    run_out_death("eat_out");

    // Game over after three lethal hits
    do_reset();
    mv = 1'b1;
    n_defeat = 0;
    for (int h = 0; h < 3; h++) begin
      gx[2] = 304; gy[2] = 248; fr = '0;
      tick("go_hit");
      ghosts_away();
      for (int k = 0; k < DF; k++) begin
        tick("go_freeze");
        if (h == 2 && isDefeated) n_defeat++;
      end
      if (h < 2) begin
        mv = 1'b0; tick("go_recentre"); mv = 1'b1;
      end
    end
    chk("gameover.game_over", int'(game_over), 1);
    chk("gameover.death", int'(death), 1);
    chk("gameover.lives", int'(lives), 0);
    chk("gameover.no_defeat", n_defeat, 0);
    for (int k = 0; k < 20; k++) begin
      mv = 1'($urandom_range(0, 1));
      gx[0] = 300 + $urandom_range(0, 8); gy[0] = 248;
      fr = 4'($urandom);
      tick("gameover_hold");
    end

    // Reset in the middle of the freeze
    do_reset();
    mv = 1'b1;
    gx[0] = 304; gy[0] = 248; fr = '0;
    tick("mid_hit");
    ghosts_away();
    for (int k = 0; k < 30; k++) tick("mid_freeze");
    do_reset();
    chk("midreset.lives", int'(lives), 3);
    chk("midreset.death", int'(death), 0);
    n_defeat = 0;
    for (int k = 0; k < 40; k++) begin
      tick("mid_after");
      if (isDefeated) n_defeat++;
    end
    chk("midreset.no_defeat", n_defeat, 0);

`ifdef PACMAN_EXTRA_LIFE_EN
    // Extra life saturates at 7 and cancels a simultaneous lethal hit
    xl = 1'b1;
    for (int k = 0; k < 6; k++) tick("xl_up");
    chk("xl.sat", int'(lives), 7);
    gx[0] = 304; gy[0] = 248;
    tick("xl_lethal");
    chk("xl_lethal.lives", int'(lives), 7);
    xl = 1'b0;
    ghosts_away();
    run_out_death("xl_out");
`endif

    // Random play against the model
    do_reset();
    for (int k = 0; k < 600; k++) begin
      px = 100 + $urandom_range(0, 500);
      py = 100 + $urandom_range(0, 300);
      mv = ($urandom_range(0, 9) < 8);
      for (int i = 0; i < NG; i++) begin
        if ($urandom_range(0, 9) < 2) begin
          gx[i] = px + $urandom_range(0, 16) - 8;
          gy[i] = py + $urandom_range(0, 16) - 8;
        end else begin
          gx[i] = px + 300;
          gy[i] = py + 300;
        end
      end
      fr = 4'($urandom);
`ifdef PACMAN_EXTRA_LIFE_EN
      xl = ($urandom_range(0, 19) == 0);
`endif
      tick("rand");
      if ($urandom_range(0, 149) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pacman_life_ctrl.md
Name: pacman_life_ctrl

Overview:
- Sits directly downstream of the pacman movement block. Consumes its position (BallX/BallY) and hasMoved, plus ghost positions.
- Detects pacman/ghost overlap each frame. Runs the lose-a-life / respawn / game-over sequence.
- Drives the movement block's isDefeated and death inputs. Exports the lives count and per-ghost "eaten" pulses for the ghost and score logic.

Parameters:
- NUM_GHOSTS, 4: number of ghosts checked.
- START_LIVES, 3: lives loaded at reset. Legal range 1..7.
- HIT_RADIUS, 6: overlap when both |dx| < HIT_RADIUS and |dy| < HIT_RADIUS.
- DEATH_FRAMES, 60: frames pacman stays frozen after a lethal hit.

Ports:
- Reset, input, 1: asynchronous, active-high.
- frame_clk, input, 1: clock; one edge per video frame.
- pac_x, input, 10: pacman centre X; connects to BallX.
- pac_y, input, 10: pacman centre Y; connects to BallY.
- has_moved, input, 1: pacman hasMoved.
- ghost_x, input, 10*NUM_GHOSTS: ghost i X at bits [10i+9:10i].
- ghost_y, input, 10*NUM_GHOSTS: ghost i Y, same packing.
- ghost_frightened, input, NUM_GHOSTS: ghost i is edible.
- isDefeated, output, 1: one-frame pulse; resets pacman to centre.
- death, output, 1: freezes pacman motion.
- lives, output, 3: remaining lives.
- ghost_eaten, output, NUM_GHOSTS: one-frame pulse per ghost eaten.
- game_over, output, 1: level; set when lives reach 0.

Behaviour:
- Reset (async) values: state=PLAY, lives=START_LIVES, isDefeated=0, death=0, ghost_eaten=0, game_over=0, frame counter=0, per-ghost overlap history=0.
- Overlap test for ghost i:
  - dx = |pac_x - gx_i| computed in 11 bits, unsigned result; dy likewise.
  - hit_i = (dx < HIT_RADIUS) && (dy < HIT_RADIUS).
  - Combinational on the current inputs, sampled at the frame_clk edge.
- All outputs are registered. Any response appears the frame after the sampled condition (1-frame latency).
- State PLAY:
  - Collision is armed only when has_moved=1. With has_moved=0 (spawn grace), no hit is acted on.
  - Lethal hit = any hit_i with ghost_frightened[i]=0. On a lethal hit:
    - lives decrements by 1.
    - death is set to 1.
    - frame counter is cleared.
    - go to DYING.
  - Frightened hit: ghost_eaten[i] pulses for 1 frame on the rising edge of hit_i only. Continued overlap gives no further pulse.
  - Several frightened ghosts overlapping in the same frame all pulse together.
  - Lethal takes priority: if any lethal hit occurs in a frame, all ghost_eaten stay 0 that frame.
- State DYING:
  - death=1 held; frame counter increments each frame.
  - When counter = DEATH_FRAMES-1:
    - If lives=0: set game_over=1 and go to OVER (death stays 1).
    - Otherwise: death=0 and isDefeated=1 for exactly 1 frame; go to RESPAWN.
  - Total freeze is DEATH_FRAMES frames.
  - Ghost inputs are ignored throughout DYING.
- State RESPAWN:
  - Wait for has_moved=0 (pacman has been reset), then go to PLAY.
  - isDefeated is never held longer than 1 frame.
- State OVER:
  - death=1 and game_over=1 are held; lives=0.
  - Only Reset exits this state.
- lives never underflows. It saturates at 0 and at 7.
- Reset mid-DYING or mid-RESPAWN: immediate return to the reset values; no pending pulse is emitted.
- ghost_eaten is held at 0 outside PLAY.
- The overlap history updates every frame in every state, so no spurious edge is seen on re-entering PLAY.

Optional Feature:
- Macro: PACMAN_EXTRA_LIFE_EN.
- Defined:
  - Adds input port extra_life (1 bit, pulse).
  - In PLAY, a pulse increments lives, saturating at 7.
  - If it coincides with a lethal hit, the net lives change is 0 and the DYING sequence still runs.
  - Pulses outside PLAY are ignored.
- Undefined: the port is absent and lives only decrements.

Test Plan:
1. Spawn grace: reset; pac=(304,248), ghost0=(304,248), has_moved=0 for 10 frames -> death=0, lives=3, no state change.
2. Lethal hit: has_moved=1, ghost0 not frightened, ghost0 at (309,248) with dx=5 -> next frame death=1, lives=2. death held 60 frames, then a single-frame isDefeated. Drop has_moved -> back to PLAY.
3. Radius boundary: ghost0 at (310,248) with dx=6 -> no hit. At (298,243) with dx=6 -> no hit. At (299,244) -> hit.
4. Frightened eat: ghost1 frightened overlapping for 5 frames -> ghost_eaten=4'b0010 for exactly 1 frame, lives unchanged. Simultaneously overlapping a non-frightened ghost2 -> ghost_eaten=0 and death=1.
5. Game over: three successive lethal hits -> after the third DYING, game_over=1, death=1, lives=0, no isDefeated pulse. Further stimulus has no effect until Reset.
6. Reset mid-DYING at frame 30 -> lives=3, death=0, isDefeated never pulses. With PACMAN_EXTRA_LIFE_EN: extra_life pulse at lives=7 -> stays 7.
